fetch_unit: RTL and testbench

Instruction-fetch stage between the PC register and the ID stage. Each cycle the PC is not stalled, it issues the current `pc` to a synchronous instruction memory (1-cycle read latency). It captures the returned word with its PC in a small FIFO and presents it to decode over a valid/ready handshake. It drives the PC register's `stall`, performs branch-redirect flush, and flags out-of-range or misaligned fetches.

---
 rtl/cpu_defs.sv | 13 +
 rtl/fetch_queue.sv | 60 ++++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset PC, nop encoding and the fetch-queue entry record.
package cpu_defs;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries with wrap-around pointers and an occupancy counter.
// The head entry is presented combinationally from the read pointer.
module fetch_queue
    import cpu_defs::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  fetch_entry_t                 din,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output fetch_entry_t                 head
);

    localparam int            PW   = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy; clear empties the queue and wins over push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues the PC to a 1-cycle synchronous instruction memory,
// queues returned words with their PC, and hands them to decode over valid/ready.
// Issue is credit-based so a response always finds room in the queue.
module fetch_unit
    import cpu_defs::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] IM_BASE  = PC_RESET,
    parameter int          IM_WORDS = 4096
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_stall,
    output logic [31:0] im_addr,
    output logic        im_en,
    input  logic [31:0] im_rdata,
    input  logic        flush,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_exc
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [32:0] IM_END  = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);

    logic [CW-1:0] q_count;
    fetch_entry_t  q_head;
    fetch_entry_t  push_entry;
    fetch_entry_t  hold;
    fetch_entry_t  view;
    logic          push;
    logic          pop;
    logic          issue;
    logic          pc_exc;
    logic          inflight;
    logic [31:0]   req_pc;
    logic          req_exc;
    logic [CW:0]   occ_after_pop;
    logic [CW:0]   occ_now;

    assign id_valid = (q_count != '0);
    assign pop      = id_valid & id_ready;

    // Slots already claimed once this cycle's pop is taken into account; pop implies count >= 1.
    assign occ_after_pop = {1'b0, q_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign occ_now       = {1'b0, q_count} + {{CW{1'b0}}, inflight};

    assign issue    = !flush && (occ_after_pop < DEPTH_C);
    assign im_en    = issue;
    assign im_addr  = pc;
    assign pc_stall = !issue && !flush;

    assign pc_exc = (pc[1:0] != 2'b00)
                 || ({1'b0, pc} < {1'b0, IM_BASE})
                 || ({1'b0, pc} >= IM_END);

    // Tracks the single outstanding memory request and its address check result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            req_pc   <= '0;
            req_exc  <= 1'b0;
        end else if (issue) begin
            inflight <= 1'b1;
            req_pc   <= pc;
            req_exc  <= pc_exc;
        end else begin
            inflight <= 1'b0;
        end
    end

    // A response is dropped when a redirect arrives in the same cycle.
    always_comb begin
        push             = inflight && !flush;
        push_entry.instr = req_exc ? INSTR_NOP : im_rdata;
        push_entry.pc    = req_pc;
        push_entry.exc   = req_exc;
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   (push_entry),
        .count (q_count),
        .head  (q_head)
    );

    // Remembers the last presented head so outputs hold while the queue is empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold <= '0;
        end else if (id_valid) begin
            hold <= q_head;
        end
    end

    assign view     = id_valid ? q_head : hold;
    assign id_instr = view.instr;
    assign id_pc    = view.pc;
    assign id_exc   = view.exc;

    occupancy_bound: assert property (@(posedge clk) disable iff (reset) occ_now <= DEPTH_C);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a 1-cycle instruction memory model
// that returns word = address.
module tb_fetch_unit;
    import cpu_defs::*;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        rdy;
        logic        fl;
        logic        v;
        logic [31:0] hpc;
        logic [31:0] hin;
        logic        ex;
        logic        st;
        logic        en;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'h3000;
    logic        pc_stall;
    logic [31:0] im_addr;
    logic        im_en;
    logic [31:0] im_rdata = 32'h0;
    logic        flush = 1'b0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_exc;

    int total = 0;
    int bad   = 0;
    logic        en_s;
    logic [31:0] addr_s;
    vec_t        vq[$];

    fetch_unit #(.DEPTH(2), .IM_BASE(32'h0000_3000), .IM_WORDS(4096)) dut (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .pc_stall (pc_stall),
        .im_addr  (im_addr),
        .im_en    (im_en),
        .im_rdata (im_rdata),
        .flush    (flush),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_instr (id_instr),
        .id_pc    (id_pc),
        .id_exc   (id_exc)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [31:0] pcv, input logic rdy, fl, v,
                                input logic [31:0] hpc, hin, input logic ex, st, en);
        vec_t r;
        r.rst = rst; r.pc = pcv; r.rdy = rdy; r.fl = fl; r.v = v;
        r.hpc = hpc; r.hin = hin; r.ex = ex; r.st = st; r.en = en;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        id_ready = 1'b0;
        pc = 32'h3000;
        @(negedge clk);
        chk("rst_valid", -1, {31'b0, id_valid}, 32'd0);
        chk("rst_pc",    -1, id_pc, 32'h0);
        chk("rst_stall", -1, {31'b0, pc_stall}, 32'd0);
        chk("rst_im_en", -1, {31'b0, im_en}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drives one cycle of inputs, checks outputs mid-cycle, then advances the memory model.
    task automatic apply(input vec_t v, input int row);
        if (v.rst) do_reset();
        pc = v.pc;
        id_ready = v.rdy;
        flush = v.fl;
        @(negedge clk);
        chk("id_valid", row, {31'b0, id_valid}, {31'b0, v.v});
        chk("id_pc",    row, id_pc, v.hpc);
        chk("id_instr", row, id_instr, v.hin);
        chk("id_exc",   row, {31'b0, id_exc}, {31'b0, v.ex});
        chk("pc_stall", row, {31'b0, pc_stall}, {31'b0, v.st});
        chk("im_en",    row, {31'b0, im_en}, {31'b0, v.en});
        en_s = im_en;
        addr_s = im_addr;
        @(posedge clk);
        #1;
        if (en_s) im_rdata = addr_s;
    endtask

    initial begin
        // rst, pc, rdy, flush | valid, head pc, head instr, exc, stall, im_en
        // backpressure, drain, flush, address errors, streaming
        vq.push_back(mk(1, 32'h3000, 0, 0, 0, 32'h0,    32'h0,    0, 0, 1));
        vq.push_back(mk(0, 32'h3004, 0, 0, 0, 32'h0,    32'h0,    0, 0, 1));
        vq.push_back(mk(0, 32'h3008, 0, 0, 1, 32'h3000, 32'h3000, 0, 1, 0));
        vq.push_back(mk(0, 32'h3008, 0, 0, 1, 32'h3000, 32'h3000, 0, 1, 0));
        vq.push_back(mk(0, 32'h3008, 1, 0, 1, 32'h3000, 32'h3000, 0, 0, 1));
        vq.push_back(mk(0, 32'h300c, 1, 1, 1, 32'h3004, 32'h3004, 0, 0, 0));
        vq.push_back(mk(0, 32'h3100, 1, 0, 0, 32'h3004, 32'h3004, 0, 0, 1));
        vq.push_back(mk(0, 32'h3104, 1, 0, 0, 32'h3004, 32'h3004, 0, 0, 1));
        vq.push_back(mk(0, 32'h3108, 1, 0, 1, 32'h3100, 32'h3100, 0, 0, 1));
        vq.push_back(mk(0, 32'h310c, 1, 0, 1, 32'h3104, 32'h3104, 0, 0, 1));
        vq.push_back(mk(0, 32'h3002, 1, 0, 1, 32'h3108, 32'h3108, 0, 0, 1));
        vq.push_back(mk(0, 32'h2ffc, 1, 0, 1, 32'h310c, 32'h310c, 0, 0, 1));
        vq.push_back(mk(0, 32'h6ffc, 1, 0, 1, 32'h3002, 32'h0,    1, 0, 1));
        vq.push_back(mk(0, 32'h7000, 1, 0, 1, 32'h2ffc, 32'h0,    1, 0, 1));
        vq.push_back(mk(0, 32'h3010, 1, 0, 1, 32'h6ffc, 32'h6ffc, 0, 0, 1));
        vq.push_back(mk(0, 32'h3014, 1, 0, 1, 32'h7000, 32'h0,    1, 0, 1));
        vq.push_back(mk(0, 32'h3018, 1, 0, 1, 32'h3010, 32'h3010, 0, 0, 1));
        vq.push_back(mk(0, 32'h301c, 1, 0, 1, 32'h3014, 32'h3014, 0, 0, 1));
        // push and pop around a full queue with id_ready pulsed
        vq.push_back(mk(1, 32'h3000, 0, 0, 0, 32'h0,    32'h0,    0, 0, 1));
        vq.push_back(mk(0, 32'h3004, 0, 0, 0, 32'h0,    32'h0,    0, 0, 1));
        vq.push_back(mk(0, 32'h3008, 1, 0, 1, 32'h3000, 32'h3000, 0, 0, 1));
        vq.push_back(mk(0, 32'h300c, 0, 0, 1, 32'h3004, 32'h3004, 0, 1, 0));
        vq.push_back(mk(0, 32'h300c, 1, 0, 1, 32'h3004, 32'h3004, 0, 0, 1));
        vq.push_back(mk(0, 32'h3010, 0, 0, 1, 32'h3008, 32'h3008, 0, 1, 0));
        vq.push_back(mk(0, 32'h3010, 1, 0, 1, 32'h3008, 32'h3008, 0, 0, 1));
        vq.push_back(mk(0, 32'h3014, 1, 0, 1, 32'h300c, 32'h300c, 0, 0, 1));
        vq.push_back(mk(0, 32'h3018, 1, 0, 1, 32'h3010, 32'h3010, 0, 0, 1));

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], i);
        end

        // Asynchronous reset in the middle of a stream, then restart from 0x3000.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            apply(mk(0, 32'(32'h3000 + 4 * k), 1, 0, (k >= 2),
                     (k >= 2) ? 32'(32'h3000 + 4 * (k - 2)) : 32'h0,
                     (k >= 2) ? 32'(32'h3000 + 4 * (k - 2)) : 32'h0, 0, 0, 1), 100 + k);
        end
        #2 reset = 1'b1;
        #1;
        chk("async_valid", 200, {31'b0, id_valid}, 32'd0);
        chk("async_pc",    200, id_pc, 32'h0);
        chk("async_im_en", 200, {31'b0, im_en}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            apply(mk(0, 32'(32'h3000 + 4 * k), 1, 0, (k >= 2),
                     (k >= 2) ? 32'(32'h3000 + 4 * (k - 2)) : 32'h0,
                     (k >= 2) ? 32'(32'h3000 + 4 * (k - 2)) : 32'h0, 0, 0, 1), 300 + k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
